// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/memory/write-back bundle for mem_access_ctrl.
//   master : the surrounding system (control unit requests, data memory
//            busy/read data); consumes strobes, stall and write-back.
//   slave  : mem_access_ctrl itself.
// Signals:
//   rd_req, wr_req, req_addr, req_wdata, req_dest  - instruction request
//   mem_busy_wait, mem_rdata                       - data memory status/data
//   mem_read, mem_write, mem_addr, mem_wdata       - data memory strobes/bus
//   stall                                          - PC / regfile freeze
//   wb_en, wb_addr, wb_data                        - load write-back
//   illegal_req, timeout_err                       - error indications
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int REG_W  = 3
);
  logic              rd_req;
  logic              wr_req;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [REG_W-1:0]  req_dest;
  logic              mem_busy_wait;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              stall;
  logic              wb_en;
  logic [REG_W-1:0]  wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              illegal_req;
  logic              timeout_err;

  modport master (
    output rd_req, wr_req, req_addr, req_wdata, req_dest, mem_busy_wait, mem_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata, stall, wb_en, wb_addr, wb_data,
           illegal_req, timeout_err
  );

  modport slave (
    input  rd_req, wr_req, req_addr, req_wdata, req_dest, mem_busy_wait, mem_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata, stall, wb_en, wb_addr, wb_data,
           illegal_req, timeout_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one load/store at a time against a busy-wait
// data memory. Latches address/data/destination on acceptance, holds the
// strobe while the memory reports busy, stalls PC/regfile until the access
// finishes, issues a single write-back for loads, and aborts any access that
// spends TIMEOUT cycles in ISSUE+WAIT (timeout_err stays set until reset).
// Ports:
//   clk   - system clock, all state on posedge
//   reset - asynchronous active-high clear
//   bus   - mem_access_ctrl_if slave modport (requests, memory, write-back)
module mem_access_ctrl #(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 8,
  parameter int          REG_W   = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  mem_access_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ABORT} state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t            state, state_nxt;
  logic              op_store;
  logic [15:0]       cnt;
  logic [15:0]       cnt_inc;
  logic              one_req, both_req, timed_out;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [REG_W-1:0]  dest_q;
  logic [DATA_W-1:0] rdata_q;
  logic              terr_q;
  logic              rd_c, wr_c, stall_c, wb_en_c, ill_c;

  assign one_req   = bus.rd_req ^ bus.wr_req;
  assign both_req  = bus.rd_req & bus.wr_req;
  assign cnt_inc   = cnt + 16'd1;
  // Timeout beats a same-cycle busy_wait transition.
  assign timed_out = (cnt_inc == TIMEOUT_C);

  always_comb begin
    state_nxt = state;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    stall_c   = 1'b0;
    wb_en_c   = 1'b0;
    ill_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (one_req) begin
          stall_c   = 1'b1;
          state_nxt = S_ISSUE;
        end else if (both_req) begin
          ill_c = 1'b1;
        end
      end
      S_ISSUE: begin
        stall_c = 1'b1;
        rd_c    = ~op_store;
        wr_c    = op_store;
        if (timed_out)              state_nxt = S_ABORT;
        else if (bus.mem_busy_wait) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Strobe follows busy_wait so it drops in the cycle busy falls.
        stall_c = 1'b1;
        rd_c    = ~op_store & bus.mem_busy_wait;
        wr_c    = op_store & bus.mem_busy_wait;
        if (timed_out)               state_nxt = S_ABORT;
        else if (!bus.mem_busy_wait) state_nxt = S_DONE;
      end
      S_DONE: begin
        wb_en_c   = ~op_store;
        state_nxt = S_IDLE;
      end
      S_ABORT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_store <= 1'b0;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dest_q   <= '0;
      rdata_q  <= '0;
      terr_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && one_req) begin
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        dest_q   <= bus.req_dest;
        op_store <= bus.wr_req;
        cnt      <= '0;
      end else if (state == S_ISSUE || state == S_WAIT) begin
        cnt <= cnt_inc;
      end
      if (state == S_WAIT && state_nxt == S_DONE && !op_store)
        rdata_q <= bus.mem_rdata;
      if (state_nxt == S_ABORT)
        terr_q <= 1'b1;
    end
  end

  // The IDLE request decode is combinational, so gate it while reset is held.
  assign bus.mem_read    = rd_c;
  assign bus.mem_write   = wr_c;
  assign bus.stall       = stall_c & ~reset;
  assign bus.illegal_req = ill_c & ~reset;
  assign bus.wb_en       = wb_en_c;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.wb_addr     = dest_q;
  assign bus.wb_data     = rdata_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl. Each transaction is described by its kind and
// the number of cycles the memory stays busy; expected per-cycle outputs
// are derived from that description, with a byte array as the memory.
module tb_mem_access_ctrl;
  localparam int unsigned TMO = 12;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] mem [256];
  logic exp_terr = 1'b0;

  mem_access_ctrl_if #(.ADDR_W(8), .DATA_W(8), .REG_W(3)) bus ();

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(8), .REG_W(3), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic e_rd, input logic e_wr,
                           input logic e_stall, input logic e_wb, input logic e_ill);
    check({tag, ".mem_read"},    32'(bus.mem_read),    32'(e_rd));
    check({tag, ".mem_write"},   32'(bus.mem_write),   32'(e_wr));
    check({tag, ".stall"},       32'(bus.stall),       32'(e_stall));
    check({tag, ".wb_en"},       32'(bus.wb_en),       32'(e_wb));
    check({tag, ".illegal_req"}, 32'(bus.illegal_req), 32'(e_ill));
    check({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(exp_terr));
  endtask

  // Called just after a negedge. kind: 0 load, 1 store, 2 both requests.
  // n = cycles the memory holds busy_wait after seeing the strobe (n >= 1).
  // Returns in the DONE/ABORT cycle (or the illegal cycle) with requests high.
  task automatic run_txn(input int kind, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [2:0] dest, input int unsigned n);
    int unsigned last;
    logic        abort;
    logic        st;
    bus.rd_req        = (kind != 1);
    bus.wr_req        = (kind != 0);
    bus.req_addr      = addr;
    bus.req_wdata     = wdata;
    bus.req_dest      = dest;
    bus.mem_busy_wait = 1'b0;
    bus.mem_rdata     = 8'($urandom);
    #1;
    if (kind == 2) begin
      check_ctl("illegal", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      return;
    end
    st = (kind == 1);
    check_ctl("request", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    abort = (n + 1 >= TMO);
    last  = abort ? TMO : n + 1;
    for (int unsigned k = 1; k <= last; k++) begin
      @(negedge clk);
      bus.mem_busy_wait = (k <= n);
      bus.req_addr      = 8'($urandom);
      bus.req_wdata     = 8'($urandom);
      bus.req_dest      = 3'($urandom);
      bus.mem_rdata     = (k == n + 1 && !st) ? mem[addr] : 8'($urandom);
      #1;
      check_ctl("access", !st && k <= n, st && k <= n, 1'b1, 1'b0, 1'b0);
      check("mem_addr",  32'(bus.mem_addr),  32'(addr));
      check("mem_wdata", 32'(bus.mem_wdata), 32'(wdata));
    end
    @(negedge clk);
    bus.mem_busy_wait = 1'b0;
    if (abort) exp_terr = 1'b1;
    #1;
    if (abort) begin
      check_ctl("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      check_ctl("done", 1'b0, 1'b0, 1'b0, !st, 1'b0);
      if (!st) begin
        check("wb_addr", 32'(bus.wb_addr), 32'(dest));
        check("wb_data", 32'(bus.wb_data), 32'(mem[addr]));
      end else begin
        mem[addr] = wdata;
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    #1;
    check_ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    reset             = 1'b1;
    bus.rd_req        = 1'b1;
    bus.wr_req        = 1'b0;
    bus.req_addr      = 8'h20;
    bus.req_wdata     = 8'h00;
    bus.req_dest      = 3'd2;
    bus.mem_busy_wait = 1'b0;
    bus.mem_rdata     = 8'h00;

    // Reset with a load pending: everything quiet.
    #3;
    check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.mem_addr",  32'(bus.mem_addr),  32'd0);
    check("reset.mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("reset.wb_addr",   32'(bus.wb_addr),   32'd0);
    check("reset.wb_data",   32'(bus.wb_data),   32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_txn(0, 8'h20, 8'h00, 3'd2, 3);
    go_idle();

    // Store 0x11 to 0x04 then load it back to r5, back-to-back, 10 busy cycles.
    @(negedge clk);
    run_txn(1, 8'h04, 8'h11, 3'd0, 10);
    @(negedge clk);
    run_txn(0, 8'h04, 8'h5a, 3'd5, 10);
    check("b2b.load_value", 32'(bus.wb_data), 32'h11);
    go_idle();

    // Both requests at once.
    @(negedge clk);
    run_txn(2, 8'h33, 8'h44, 3'd1, 1);
    go_idle();

    // Busy falls on the very edge the timeout expires: abort wins.
    @(negedge clk);
    run_txn(0, 8'h40, 8'h00, 3'd3, TMO - 1);
    go_idle();
    // Memory never releases.
    @(negedge clk);
    run_txn(1, 8'h41, 8'h99, 3'd0, 40);
    go_idle();
    // Largest access that still completes.
    @(negedge clk);
    run_txn(0, 8'h04, 8'h00, 3'd7, TMO - 2);
    go_idle();

    // Reset in the middle of WAIT.
    @(negedge clk);
    bus.rd_req = 1'b1; bus.wr_req = 1'b0; bus.req_addr = 8'h04; bus.req_dest = 3'd6;
    @(negedge clk);
    bus.mem_busy_wait = 1'b1;
    @(negedge clk);
    #1;
    check_ctl("mid_wait", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    exp_terr = 1'b0;
    #1;
    check_ctl("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.rd_req = 1'b0;
    bus.mem_busy_wait = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_ctl("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run_txn(0, 8'h04, 8'h00, 3'd6, 2);
    go_idle();

    // Random mix of loads, stores, conflicting requests, timeouts, back-to-back.
    for (int t = 0; t < 60; t++) begin
      int          kind;
      int unsigned n;
      int          sel;
      sel  = $urandom_range(0, 6);
      kind = (sel < 3) ? 0 : (sel < 6) ? 1 : 2;
      n    = $urandom_range(1, TMO + 1);
      @(negedge clk);
      run_txn(kind, 8'($urandom_range(0, 15)), 8'($urandom), 3'($urandom), n);
      if ($urandom_range(0, 1) == 0) go_idle();
    end
    go_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
